// File: rtl/turbosound_ctrl.sv
// TurboSound bus sequencer: shares the #FFFD/#BFFD PSG port pair between two YM2149 chips.
// Optional build macro TS_MODE_CTRL_EN: ADDR-port bytes #FD/#FC set MODE_OUT instead of strobing.
module turbosound_ctrl #(
  parameter int unsigned CE_DIV       = 16,
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter bit          DEFAULT_MODE = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] BUS_A,
  input  logic [7:0]  BUS_DI,
  input  logic        BUS_IORQ_N,
  input  logic        BUS_RD_N,
  input  logic        BUS_WR_N,
  input  logic        BUS_M1_N,
  input  logic [7:0]  PSG_DO0,
  input  logic [7:0]  PSG_DO1,
  output logic        PSG_CE,
  output logic [7:0]  PSG_DI,
  output logic        PSG_BDIR0,
  output logic        PSG_BC0,
  output logic        PSG_BDIR1,
  output logic        PSG_BC1,
  output logic        MODE_OUT,
  output logic        CHIP_SEL,
  output logic [7:0]  BUS_DO,
  output logic        BUS_DO_OE
);

  typedef enum logic [2:0] {StIdle, StCapture, StStrobe, StRelease, StWaitEnd} state_e;

  state_e     state_q, state_d;
  logic [1:0] iorq_sync_q, rd_sync_q, wr_sync_q;
  logic       armed_q, armed_d;
  logic [7:0] div_q, div_d;
  logic       ce_q;
  logic [7:0] psg_di_q;
  logic       is_addr_q, chip_sel_q;
  logic [3:0] hold_q;
  logic       iorq_s, iow, ior, iow_rise;
  logic       addr_dec, data_dec, intercept, read_en;
  logic       unused_addr;

  assign unused_addr = ^{BUS_A[13:2], BUS_A[0]};

  // IORQ sync resets to "asserted" and armed_q only sets once IORQ is seen high, so a
  // cycle still in progress when reset is released never looks like a fresh edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      iorq_sync_q <= 2'b00;
      rd_sync_q   <= 2'b11;
      wr_sync_q   <= 2'b11;
      armed_q     <= 1'b0;
    end else begin
      iorq_sync_q <= {iorq_sync_q[0], BUS_IORQ_N};
      rd_sync_q   <= {rd_sync_q[0], BUS_RD_N};
      wr_sync_q   <= {wr_sync_q[0], BUS_WR_N};
      armed_q     <= armed_d;
    end
  end

  assign iorq_s   = iorq_sync_q[1];
  assign iow      = !iorq_s && !wr_sync_q[1] && BUS_M1_N;
  assign ior      = !iorq_s && !rd_sync_q[1] && BUS_M1_N;
  assign armed_d  = iorq_s ? 1'b1 : (iow ? 1'b0 : armed_q);
  assign iow_rise = iow && armed_q;
  assign addr_dec = (BUS_A[15:14] == 2'b11) && !BUS_A[1];
  assign data_dec = (BUS_A[15:14] == 2'b10) && !BUS_A[1];

  // Free-running clock-enable divider; ce_q mirrors "count is zero" as a register.
  assign div_d = (div_q == 8'd0) ? 8'(CE_DIV - 1) : div_q - 8'd1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q <= 8'd0;
      ce_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      ce_q  <= (div_d == 8'd0);
    end
  end

  always_comb begin
    intercept = addr_dec && (BUS_DI == 8'hFF || BUS_DI == 8'hFE);
`ifdef TS_MODE_CTRL_EN
    intercept = intercept || (addr_dec && (BUS_DI == 8'hFD || BUS_DI == 8'hFC));
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (iow_rise && (addr_dec || data_dec)) state_d = StCapture;
      StCapture: state_d = intercept ? StWaitEnd : StStrobe;
      StStrobe:  if (hold_q == 4'd0) state_d = StRelease;
      StRelease: state_d = StWaitEnd;
      StWaitEnd: if (iorq_s) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      psg_di_q   <= 8'd0;
      is_addr_q  <= 1'b0;
      chip_sel_q <= 1'b0;
      hold_q     <= 4'd0;
    end else if (state_q == StCapture) begin
      psg_di_q  <= BUS_DI;
      is_addr_q <= addr_dec;
      hold_q    <= 4'(HOLD_CYCLES - 1);
      if (addr_dec && BUS_DI == 8'hFF) chip_sel_q <= 1'b0;
      if (addr_dec && BUS_DI == 8'hFE) chip_sel_q <= 1'b1;
    end else if (state_q == StStrobe && hold_q != 4'd0) begin
      hold_q <= hold_q - 4'd1;
    end
  end

`ifdef TS_MODE_CTRL_EN
  logic mode_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q <= DEFAULT_MODE;
    end else if (state_q == StCapture && addr_dec) begin
      if (BUS_DI == 8'hFD) mode_q <= 1'b1;
      if (BUS_DI == 8'hFC) mode_q <= 1'b0;
    end
  end

  assign MODE_OUT = mode_q;
`else
  assign MODE_OUT = DEFAULT_MODE;
`endif

  assign read_en = ior && addr_dec && (state_q == StIdle);

  // Write strobe wins over the read path; the two never share a CPU cycle.
  always_comb begin
    PSG_BDIR0 = 1'b0;
    PSG_BC0   = 1'b0;
    PSG_BDIR1 = 1'b0;
    PSG_BC1   = 1'b0;
    BUS_DO    = 8'hFF;
    BUS_DO_OE = 1'b0;
    if (state_q == StStrobe) begin
      if (chip_sel_q) begin
        PSG_BDIR1 = 1'b1;
        PSG_BC1   = is_addr_q;
      end else begin
        PSG_BDIR0 = 1'b1;
        PSG_BC0   = is_addr_q;
      end
    end else if (read_en) begin
      BUS_DO_OE = 1'b1;
      if (chip_sel_q) begin
        PSG_BC1 = 1'b1;
        BUS_DO  = PSG_DO1;
      end else begin
        PSG_BC0 = 1'b1;
        BUS_DO  = PSG_DO0;
      end
    end
  end

  assign PSG_CE   = ce_q;
  assign PSG_DI   = psg_di_q;
  assign CHIP_SEL = chip_sel_q;

endmodule

// File: tb/tb_turbosound_ctrl.sv
// Randomized bench for turbosound_ctrl: CPU I/O cycles checked against a transaction-level model.
module tb_turbosound_ctrl;

  localparam int unsigned CeDiv   = 16;
  localparam int unsigned Hold    = 2;
  localparam bit          DefMode = 1'b0;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic [15:0] BUS_A = 16'h0000;
  logic [7:0]  BUS_DI = 8'h00;
  logic        BUS_IORQ_N = 1'b1;
  logic        BUS_RD_N = 1'b1;
  logic        BUS_WR_N = 1'b1;
  logic        BUS_M1_N = 1'b1;
  logic [7:0]  PSG_DO0 = 8'h00;
  logic [7:0]  PSG_DO1 = 8'h00;
  logic        PSG_CE;
  logic [7:0]  PSG_DI;
  logic        PSG_BDIR0, PSG_BC0, PSG_BDIR1, PSG_BC1;
  logic        MODE_OUT, CHIP_SEL;
  logic [7:0]  BUS_DO;
  logic        BUS_DO_OE;

  turbosound_ctrl #(
    .CE_DIV      (CeDiv),
    .HOLD_CYCLES (Hold),
    .DEFAULT_MODE(DefMode)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .BUS_A     (BUS_A),
    .BUS_DI    (BUS_DI),
    .BUS_IORQ_N(BUS_IORQ_N),
    .BUS_RD_N  (BUS_RD_N),
    .BUS_WR_N  (BUS_WR_N),
    .BUS_M1_N  (BUS_M1_N),
    .PSG_DO0   (PSG_DO0),
    .PSG_DO1   (PSG_DO1),
    .PSG_CE    (PSG_CE),
    .PSG_DI    (PSG_DI),
    .PSG_BDIR0 (PSG_BDIR0),
    .PSG_BC0   (PSG_BC0),
    .PSG_BDIR1 (PSG_BDIR1),
    .PSG_BC1   (PSG_BC1),
    .MODE_OUT  (MODE_OUT),
    .CHIP_SEL  (CHIP_SEL),
    .BUS_DO    (BUS_DO),
    .BUS_DO_OE (BUS_DO_OE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: which chip is selected, MODE, and strobes the PSGs should see.
  logic        m_sel  = 1'b0;
  logic        m_mode = DefMode;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];

  function automatic logic [23:0] pack_strobe(input logic chip, input logic bc, input logic [7:0] d,
                                              input int len);
    return {8'(len), 6'd0, chip, bc, d};
  endfunction

  function automatic bit is_addr_port(input logic [15:0] a);
    return a[15:14] == 2'b11 && a[1] == 1'b0;
  endfunction

  function automatic bit is_data_port(input logic [15:0] a);
    return a[15:14] == 2'b10 && a[1] == 1'b0;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    if (is_addr_port(a)) begin
      if (d == 8'hFF) m_sel = 1'b0;
      else if (d == 8'hFE) m_sel = 1'b1;
`ifdef TS_MODE_CTRL_EN
      else if (d == 8'hFD) m_mode = 1'b1;
      else if (d == 8'hFC) m_mode = 1'b0;
`endif
      else exp_q.push_back(pack_strobe(m_sel, 1'b1, d, Hold));
    end else if (is_data_port(a)) begin
      exp_q.push_back(pack_strobe(m_sel, 1'b0, d, Hold));
    end
  endtask

  // Strobe monitor: collapses each BDIR-high run into one record.
  bit          mon_en = 1'b1;
  int          run_len = 0;
  logic        run_chip, run_bc;
  logic [7:0]  run_di;
  int          glitches = 0;

  always @(negedge CLK) begin
    if (!mon_en || !RESET_N) begin
      run_len = 0;
    end else if (PSG_BDIR0 || PSG_BDIR1) begin
      if (PSG_BDIR0 && PSG_BDIR1) glitches++;
      if (run_len == 0) begin
        run_chip = PSG_BDIR1;
        run_bc   = PSG_BDIR1 ? PSG_BC1 : PSG_BC0;
        run_di   = PSG_DI;
      end else if (run_chip != PSG_BDIR1 || run_di != PSG_DI ||
                   run_bc != (run_chip ? PSG_BC1 : PSG_BC0)) begin
        glitches++;
      end
      if (run_chip ? PSG_BC0 : PSG_BC1) glitches++;
      run_len++;
    end else if (run_len != 0) begin
      obs_q.push_back(pack_strobe(run_chip, run_bc, run_di, run_len));
      run_len = 0;
    end
  end

  task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(negedge CLK);
    BUS_A = a; BUS_DI = d; BUS_IORQ_N = 1'b0; BUS_WR_N = 1'b0;
    repeat (hold) @(negedge CLK);
    BUS_IORQ_N = 1'b1; BUS_WR_N = 1'b1;
    repeat (4) @(negedge CLK);
    model_write(a, d);
    check_eq("chip_sel", {31'd0, CHIP_SEL}, {31'd0, m_sel});
    check_eq("mode_out", {31'd0, MODE_OUT}, {31'd0, m_mode});
  endtask

  task automatic io_read(input logic [15:0] a, input logic m1_n);
    logic en;
    logic [7:0] d0, d1;
    d0 = 8'($urandom); d1 = 8'($urandom);
    @(negedge CLK);
    BUS_A = a; PSG_DO0 = d0; PSG_DO1 = d1; BUS_M1_N = m1_n;
    BUS_IORQ_N = 1'b0; BUS_RD_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    en = m1_n && is_addr_port(a);
    check_eq("rd_oe", {31'd0, BUS_DO_OE}, {31'd0, en});
    check_eq("rd_do", {24'd0, BUS_DO}, {24'd0, en ? (m_sel ? d1 : d0) : 8'hFF});
    check_eq("rd_bc0", {31'd0, PSG_BC0}, {31'd0, en && !m_sel});
    check_eq("rd_bc1", {31'd0, PSG_BC1}, {31'd0, en && m_sel});
    check_eq("rd_bdir", {30'd0, PSG_BDIR1, PSG_BDIR0}, 32'd0);
    @(negedge CLK);
    BUS_IORQ_N = 1'b1; BUS_RD_N = 1'b1; BUS_M1_N = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  // Write with the first strobe cycle pinned to the 4th CLK edge after IORQ/WR fall.
  task automatic latency_write(input logic [15:0] a, input logic [7:0] d);
    logic bdir_sel, bc_sel;
    @(negedge CLK);
    BUS_A = a; BUS_DI = d; BUS_IORQ_N = 1'b0; BUS_WR_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("lat_early", {30'd0, PSG_BDIR1, PSG_BDIR0}, 32'd0);
    @(posedge CLK);
    #1;
    bdir_sel = m_sel ? PSG_BDIR1 : PSG_BDIR0;
    bc_sel   = m_sel ? PSG_BC1 : PSG_BC0;
    check_eq("lat_bdir", {31'd0, bdir_sel}, 32'd1);
    check_eq("lat_bc", {31'd0, bc_sel}, {31'd0, is_addr_port(a)});
    check_eq("lat_di", {24'd0, PSG_DI}, {24'd0, d});
    repeat (6) @(negedge CLK);
    BUS_IORQ_N = 1'b1; BUS_WR_N = 1'b1;
    repeat (4) @(negedge CLK);
    model_write(a, d);
  endtask

  initial begin
    int ce_pos[$];
    bit found;
    int hits;
    int n;
    logic [15:0] a;
    logic [7:0]  d;

    #3 RESET_N = 1'b0;
    #1;
    check_eq("rst_ce", {31'd0, PSG_CE}, 32'd0);
    check_eq("rst_ctrl", {28'd0, PSG_BDIR0, PSG_BC0, PSG_BDIR1, PSG_BC1}, 32'd0);
    check_eq("rst_di", {24'd0, PSG_DI}, 32'd0);
    check_eq("rst_sel", {31'd0, CHIP_SEL}, 32'd0);
    check_eq("rst_mode", {31'd0, MODE_OUT}, {31'd0, DefMode});
    check_eq("rst_do", {23'd0, BUS_DO_OE, BUS_DO}, 32'h0FF);
    repeat (4) @(negedge CLK);
    RESET_N = 1'b1;

    // Clock-enable divider period and width.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      if (PSG_CE) found = 1'b1;
    end
    check_eq("ce_found", {31'd0, found}, 32'd1);
    for (int i = 1; i <= 64; i++) begin
      @(negedge CLK);
      if (PSG_CE) ce_pos.push_back(i);
    end
    check_eq("ce_count", ce_pos.size(), 4);
    for (int i = 0; i < ce_pos.size() && i < 4; i++) check_eq("ce_pos", ce_pos[i], CeDiv * (i + 1));

    // Directed sequence: chip 0 address/data, select chip 1, read back, reselect chip 0.
    latency_write(16'hFFFD, 8'h07);
    io_write(16'hBFFD, 8'h3E, 8);
    io_write(16'hFFFD, 8'hFE, 8);
    io_write(16'hFFFD, 8'h08, 8);
    io_write(16'hBFFD, 8'h0F, 8);
    io_read(16'hFFFD, 1'b1);
    io_read(16'hFFFD, 1'b0);
    io_write(16'hFFFD, 8'hFF, 8);
    io_write(16'hFFFD, 8'hFD, 8);
    io_write(16'hFFFD, 8'hFC, 8);
    io_write(16'hBFFD, 8'h99, 40);

    // Reset in the middle of a strobe, with IORQ/WR still low afterwards.
    mon_en = 1'b0;
    @(negedge CLK);
    BUS_A = 16'hBFFD; BUS_DI = 8'h55; BUS_IORQ_N = 1'b0; BUS_WR_N = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check_eq("rst_pre_bdir", {31'd0, m_sel ? PSG_BDIR1 : PSG_BDIR0}, 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    check_eq("rst_mid_bdir", {30'd0, PSG_BDIR1, PSG_BDIR0}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    m_sel = 1'b0; m_mode = DefMode;
    hits = 0;
    repeat (30) begin
      @(negedge CLK);
      if (PSG_BDIR0 || PSG_BDIR1) hits++;
    end
    check_eq("rst_no_retrigger", hits, 0);
    BUS_IORQ_N = 1'b1; BUS_WR_N = 1'b1;
    repeat (4) @(negedge CLK);
    mon_en = 1'b1;
    io_write(16'hBFFD, 8'h24, 8);

    // Random traffic.
    for (int t = 0; t < 160; t++) begin
      a = 16'($urandom);
      d = 8'($urandom);
      n = $urandom_range(0, 9);
      if (n <= 3) begin
        a[15:14] = 2'b11; a[1] = 1'b0;
        case ($urandom_range(0, 7))
          0: d = 8'hFF;
          1: d = 8'hFE;
          2: d = 8'hFD;
          3: d = 8'hFC;
          default: ;
        endcase
        io_write(a, d, $urandom_range(6, 12));
      end else if (n <= 6) begin
        a[15:14] = 2'b10; a[1] = 1'b0;
        io_write(a, d, ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(6, 12));
      end else if (n == 7) begin
        a[1] = 1'b1;
        io_write(a, d, $urandom_range(6, 12));
      end else if (n == 8) begin
        a[15:14] = 2'b11; a[1] = 1'b0;
        io_read(a, 1'b1);
      end else begin
        if ($urandom_range(0, 1) == 0) begin
          a[15:14] = 2'b11; a[1] = 1'b0;
          io_read(a, 1'b0);
        end else begin
          a[15:14] = 2'b10; a[1] = 1'b0;
          io_read(a, 1'b1);
        end
      end
    end

    repeat (10) @(negedge CLK);
    check_eq("strobe_glitches", glitches, 0);
    check_eq("strobe_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check_eq($sformatf("strobe[%0d]", i), {8'd0, obs_q[i]}, {8'd0, exp_q[i]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
